// File: rtl/lc3_mem_responder_if.sv
// Core-to-memory bus for the LC3 responder: fetch port and data port.
// The core drives requests (master); the responder returns data and completions (slave).
interface lc3_mem_responder_if;
    logic [15:0] pc;
    logic        instrmem_rd;
    logic [15:0] Instr_dout;
    logic        complete_instr;
    logic        Data_en;
    logic        Data_rd;
    logic [15:0] Data_addr;
    logic [15:0] Data_din;
    logic [15:0] Data_dout;
    logic        complete_data;

    modport master (
        output pc, instrmem_rd, Data_en, Data_rd, Data_addr, Data_din,
        input  Instr_dout, complete_instr, Data_dout, complete_data
    );

    modport slave (
        input  pc, instrmem_rd, Data_en, Data_rd, Data_addr, Data_din,
        output Instr_dout, complete_instr, Data_dout, complete_data
    );
endinterface

// File: rtl/lc3_mem_responder.sv
// Latency-parameterised fetch/data responder over one shared, unreset word array.
// Optional feature: define LC3_MEM_STALL_EN to add 0-3 LFSR-driven wait cycles on the data port.
module lc3_mem_responder #(
    parameter int unsigned AW        = 12,
    parameter int unsigned INSTR_LAT = 1,
    parameter int unsigned DATA_LAT  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    lc3_mem_responder_if.slave     bus
);
    localparam int unsigned DEPTH = 1 << AW;
`ifdef LC3_MEM_STALL_EN
    localparam int unsigned D_EXTRA = 3;
`else
    localparam int unsigned D_EXTRA = 0;
`endif
    localparam int unsigned ICW = (INSTR_LAT < 2) ? 1 : $clog2(INSTR_LAT);
    localparam int unsigned DCW = ((DATA_LAT + D_EXTRA) < 2) ? 1 : $clog2(DATA_LAT + D_EXTRA);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_e;

    logic [15:0]    mem_q [DEPTH];

    state_e         i_state_q;
    logic [ICW-1:0] i_cnt_q;
    logic [AW-1:0]  i_addr_q;
    logic [15:0]    i_dout_q;
    logic           i_cmpl_q;

    state_e         d_state_q;
    logic [DCW-1:0] d_cnt_q;
    logic [AW-1:0]  d_addr_q;
    logic           d_rd_q;
    logic [15:0]    d_din_q;
    logic [15:0]    d_dout_q;
    logic           d_cmpl_q;
    logic [DCW-1:0] d_load_c;
    logic           d_wr_c;

    // Upper address bits alias away by design.
    logic unused_addr_c;
    assign unused_addr_c = &{1'b0, bus.pc, bus.Data_addr};

`ifdef LC3_MEM_STALL_EN
    logic [7:0] lfsr_q;

    // 8-bit Fibonacci LFSR, taps 8,6,5,4, free-running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr_q <= 8'hA5;
        else        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    assign d_load_c = DCW'(DATA_LAT - 1) + DCW'(lfsr_q[1:0]);
`else
    assign d_load_c = DCW'(DATA_LAT - 1);
`endif

    // Write commits only from a live WAIT state, so a reset mid-access drops it.
    assign d_wr_c = (d_state_q == ST_WAIT) && (d_cnt_q == '0) && !d_rd_q;

    always_ff @(posedge clk) begin
        if (d_wr_c) mem_q[d_addr_q] <= d_din_q;
    end

    // Fetch port. The DONE->IDLE edge doubles as an accept edge for a held request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_state_q <= ST_IDLE;
            i_cnt_q   <= '0;
            i_addr_q  <= '0;
            i_dout_q  <= 16'h0000;
            i_cmpl_q  <= 1'b0;
        end else begin
            i_cmpl_q <= 1'b0;
            case (i_state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.instrmem_rd) begin
                        i_addr_q  <= bus.pc[AW-1:0];
                        i_cnt_q   <= ICW'(INSTR_LAT - 1);
                        i_state_q <= ST_WAIT;
                    end else begin
                        i_state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (i_cnt_q == '0) begin
                        i_dout_q  <= mem_q[i_addr_q];
                        i_cmpl_q  <= 1'b1;
                        i_state_q <= ST_DONE;
                    end else begin
                        i_cnt_q <= i_cnt_q - ICW'(1);
                    end
                end
                default: i_state_q <= ST_IDLE;
            endcase
        end
    end

    // Data port; a same-edge fetch sees the pre-write word via nonblocking update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_state_q <= ST_IDLE;
            d_cnt_q   <= '0;
            d_addr_q  <= '0;
            d_rd_q    <= 1'b0;
            d_din_q   <= 16'h0000;
            d_dout_q  <= 16'h0000;
            d_cmpl_q  <= 1'b0;
        end else begin
            d_cmpl_q <= 1'b0;
            case (d_state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.Data_en) begin
                        d_addr_q  <= bus.Data_addr[AW-1:0];
                        d_rd_q    <= bus.Data_rd;
                        d_din_q   <= bus.Data_din;
                        d_cnt_q   <= d_load_c;
                        d_state_q <= ST_WAIT;
                    end else begin
                        d_state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (d_cnt_q == '0) begin
                        if (d_rd_q) d_dout_q <= mem_q[d_addr_q];
                        d_cmpl_q  <= 1'b1;
                        d_state_q <= ST_DONE;
                    end else begin
                        d_cnt_q <= d_cnt_q - DCW'(1);
                    end
                end
                default: d_state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.Instr_dout     = i_dout_q;
    assign bus.complete_instr = i_cmpl_q;
    assign bus.Data_dout      = d_dout_q;
    assign bus.complete_data  = d_cmpl_q;
endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder: reset, write/read, fetch streaming, collision, reset abort, aliasing, latency.
module tb_lc3_mem_responder;
    localparam int unsigned AW = 8;
    localparam int unsigned IL = 1;
    localparam int unsigned DL = 2;
`ifdef LC3_MEM_STALL_EN
    localparam int LMAX = DL + 3;
    localparam int NLAT = 100;
`else
    localparam int LMAX = DL;
    localparam int NLAT = 20;
`endif
    localparam int LMIN = DL;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    lc3_mem_responder_if bus ();

    lc3_mem_responder #(.AW(AW), .INSTR_LAT(IL), .DATA_LAT(DL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic idle_inputs();
        bus.pc = 16'h0; bus.instrmem_rd = 1'b0;
        bus.Data_en = 1'b0; bus.Data_rd = 1'b0; bus.Data_addr = 16'h0; bus.Data_din = 16'h0;
    endtask

    // Issue one data access; returns accept-to-complete cycles (-1 on timeout) and Data_dout at completion.
    task automatic do_data(input logic rd, input logic [15:0] addr, input logic [15:0] din,
                           output int lat, output logic [15:0] dout);
        @(negedge clk);
        bus.Data_en = 1'b1; bus.Data_rd = rd; bus.Data_addr = addr; bus.Data_din = din;
        @(posedge clk);
        @(negedge clk);
        bus.Data_en = 1'b0; bus.Data_rd = ~rd; bus.Data_addr = 16'hFFFF; bus.Data_din = 16'hDEAD;
        lat = -1; dout = 16'hxxxx;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (bus.complete_data) begin lat = k; dout = bus.Data_dout; break; end
        end
    endtask

    task automatic do_fetch(input logic [15:0] addr, output int lat, output logic [15:0] dout);
        @(negedge clk);
        bus.instrmem_rd = 1'b1; bus.pc = addr;
        @(posedge clk);
        @(negedge clk);
        bus.instrmem_rd = 1'b0; bus.pc = 16'hFFFF;
        lat = -1; dout = 16'hxxxx;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (bus.complete_instr) begin lat = k; dout = bus.Instr_dout; break; end
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bus.pc = 16'($urandom); bus.instrmem_rd = 1'($urandom);
            bus.Data_en = 1'($urandom); bus.Data_rd = 1'($urandom);
            bus.Data_addr = 16'($urandom); bus.Data_din = 16'($urandom);
            @(posedge clk); #1;
            checks++;
            if (bus.complete_instr !== 1'b0 || bus.complete_data !== 1'b0) begin
                errors++; $display("FAIL reset_complete cyc=%0d got ci=%b cd=%b want 0", c, bus.complete_instr, bus.complete_data);
            end
            checks++;
            if (bus.Instr_dout !== 16'h0000 || bus.Data_dout !== 16'h0000) begin
                errors++; $display("FAIL reset_dout cyc=%0d got i=%h d=%h want 0000", c, bus.Instr_dout, bus.Data_dout);
            end
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.complete_instr !== 1'b0 || bus.complete_data !== 1'b0) begin
                errors++; $display("FAIL post_reset_spurious cyc=%0d got ci=%b cd=%b want 0", c, bus.complete_instr, bus.complete_data);
            end
        end
    endtask

    task automatic test_write_read();
        int lat; logic [15:0] d;
        do_data(1'b0, 16'h3000, 16'h1234, lat, d);
        checks++;
        if (lat < LMIN || lat > LMAX) begin errors++; $display("FAIL write_latency got %0d want %0d..%0d", lat, LMIN, LMAX); end
        do_data(1'b1, 16'h3000, 16'h0000, lat, d);
        checks++;
        if (lat < LMIN || lat > LMAX) begin errors++; $display("FAIL read_latency got %0d want %0d..%0d", lat, LMIN, LMAX); end
        checks++;
        if (d !== 16'h1234) begin errors++; $display("FAIL read_data got %h want 1234", d); end
        do_data(1'b0, 16'h3001, 16'h7777, lat, d);
        checks++;
        if (d !== 16'h1234) begin errors++; $display("FAIL dout_hold_on_write got %h want 1234", d); end
    endtask

    task automatic test_fetch();
        logic exp;
        @(negedge clk);
        bus.instrmem_rd = 1'b1; bus.pc = 16'h3000;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            exp = (k % 2) == 1;
            checks++;
            if (bus.complete_instr !== exp) begin
                errors++; $display("FAIL fetch_pulse k=%0d got %b want %b", k, bus.complete_instr, exp);
            end
            if (exp) begin
                checks++;
                if (bus.Instr_dout !== 16'h1234) begin errors++; $display("FAIL fetch_data k=%0d got %h want 1234", k, bus.Instr_dout); end
            end
        end
        @(negedge clk);
        bus.instrmem_rd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.complete_instr !== 1'b0) begin errors++; $display("FAIL fetch_stop got %b want 0", bus.complete_instr); end
    endtask

    task automatic test_collision();
        int lat; logic [15:0] d;
        @(negedge clk);
        bus.Data_en = 1'b1; bus.Data_rd = 1'b0; bus.Data_addr = 16'h3000; bus.Data_din = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        bus.Data_en = 1'b0;
        bus.instrmem_rd = 1'b1; bus.pc = 16'h3000;
        @(posedge clk);
        @(negedge clk);
        bus.instrmem_rd = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.complete_instr !== 1'b1 || bus.complete_data !== 1'b1) begin
            errors++; $display("FAIL collision_align got ci=%b cd=%b want 1 1", bus.complete_instr, bus.complete_data);
        end
        checks++;
        if (bus.Instr_dout !== 16'h1234) begin errors++; $display("FAIL collision_old_value got %h want 1234", bus.Instr_dout); end
        repeat (2) @(posedge clk);
        do_fetch(16'h3000, lat, d);
        checks++;
        if (lat !== 1 || d !== 16'hBEEF) begin errors++; $display("FAIL collision_new_value got lat=%0d d=%h want 1 beef", lat, d); end
    endtask

    task automatic test_reset_mid_write();
        int lat; logic [15:0] d;
        do_data(1'b0, 16'h0010, 16'h0000, lat, d);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.Data_en = 1'b1; bus.Data_rd = 1'b0; bus.Data_addr = 16'h0010; bus.Data_din = 16'h5555;
        @(posedge clk);
        @(negedge clk);
        bus.Data_en = 1'b0;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.complete_data !== 1'b0) begin errors++; $display("FAIL abort_no_complete cyc=%0d got %b want 0", c, bus.complete_data); end
        end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.complete_data !== 1'b0) begin errors++; $display("FAIL abort_after_release cyc=%0d got %b want 0", c, bus.complete_data); end
        end
        do_data(1'b1, 16'h0010, 16'h0000, lat, d);
        checks++;
        if (lat < LMIN || lat > LMAX || d !== 16'h0000) begin
            errors++; $display("FAIL abort_no_commit got lat=%0d d=%h want 0000", lat, d);
        end
    endtask

    task automatic test_alias();
        int lat; logic [15:0] d;
        do_data(1'b0, 16'h0105, 16'hCAFE, lat, d);
        do_data(1'b1, 16'h0005, 16'h0000, lat, d);
        checks++;
        if (d !== 16'hCAFE) begin errors++; $display("FAIL alias_read got %h want cafe", d); end
    endtask

    task automatic test_latency();
        int lat; logic [15:0] d; logic [15:0] v; int bad;
        bad = 0;
        for (int i = 0; i < NLAT; i++) begin
            v = 16'(i * 3 + 16'h0A01);
            do_data(1'b0, 16'(16'h0040 + (i % 16)), v, lat, d);
            if (lat < LMIN || lat > LMAX) bad++;
            do_data(1'b1, 16'(16'h0040 + (i % 16)), 16'h0000, lat, d);
            if (lat < LMIN || lat > LMAX || d !== v) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL latency_sweep got %0d bad accesses want 0", bad); end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_write_read();
        test_fetch();
`ifndef LC3_MEM_STALL_EN
        test_collision();
`endif
        test_reset_mid_write();
        test_alias();
        test_latency();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
